// File: rtl/uart_alu_frontend_if.sv
// Bus bundle between the UART RX/TX pair, the ALU and uart_alu_frontend.
// slave = frontend side, master = surrounding top level / testbench side.
interface uart_alu_frontend_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              tx_done;
  logic [DATA_W-1:0] alu_result;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [OP_W-1:0]   opcode;
  logic              busy;
  logic              err;

  modport slave (
    input  rx_data, rx_done, tx_done, alu_result,
    output tx_data, tx_start, A, B, opcode, busy, err
  );

  modport master (
    output rx_data, rx_done, tx_done, alu_result,
    input  tx_data, tx_start, A, B, opcode, busy, err
  );
endinterface

// File: rtl/uart_alu_frontend.sv
// Parses "A op B " ASCII-decimal frames from UART RX, drives the ALU and returns the result as ASCII decimal + TERM.
// Optional macro SIGNED_EN: leading '-' on operands and signed result printing.
module uart_alu_frontend #(
  parameter int         DATA_W     = 32,
  parameter int         OP_W       = 6,
  parameter logic [7:0] DELIM      = 8'h20,
  parameter logic [7:0] TERM       = 8'h0D,
  parameter int         MAX_DIGITS = 10,
  parameter int         ALU_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  uart_alu_frontend_if.slave bus
);
`ifdef SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif
  localparam int IW = $clog2(MAX_DIGITS + 1);
  localparam int BW = $clog2(DATA_W);
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_A_DIG, S_OPC, S_OPC_DLM, S_B_DIG,
    S_ALU_WAIT, S_CONV, S_TX_BYTE, S_TX_WAIT, S_ERR
  } state_t;

  typedef enum logic [1:0] {K_SIGN, K_DIG, K_QMARK, K_TERM} kind_t;

  state_t            r_state;
  kind_t             r_kind;
  logic              r_rx_d, r_tx_d;
  logic [DATA_W-1:0] r_acc;
  logic              r_have, r_neg;
  logic [DATA_W-1:0] r_a_pend;
  logic [OP_W-1:0]   r_op_pend;
  logic [DATA_W-1:0] r_a, r_b;
  logic [OP_W-1:0]   r_op;
  logic [LW-1:0]     r_lat;
  logic [DATA_W-1:0] r_quot;
  logic [3:0]        r_rem;
  logic [BW-1:0]     r_bit;
  logic [3:0]        r_dig [MAX_DIGITS];
  logic [IW-1:0]     r_ndig, r_tx_idx;
  logic              r_res_neg;
  logic [7:0]        r_tx_data;
  logic              r_tx_start, r_busy, r_err;

  logic              w_rx_ev, w_tx_ev, w_is_dig, w_is_dlm, w_minus_ok;
  logic [DATA_W-1:0] w_acc_nx, w_acc_sgn;
  logic              w_op_ok;
  logic [OP_W-1:0]   w_op_code;
  logic [4:0]        w_rem_sh;
  logic              w_ge;
  logic [3:0]        w_rem_nx;
  logic [DATA_W-1:0] w_quot_nx;
  logic              w_res_neg;
  logic [DATA_W-1:0] w_res_mag;

  // Both handshakes are levels; only the rising edge counts as an event.
  assign w_rx_ev    = bus.rx_done & ~r_rx_d;
  assign w_tx_ev    = bus.tx_done & ~r_tx_d;
  assign w_is_dig   = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign w_is_dlm   = (bus.rx_data == DELIM);
  assign w_minus_ok = SIGNED_MODE && (bus.rx_data == 8'h2D) && !r_have && !r_neg;
  assign w_acc_nx   = (r_acc << 3) + (r_acc << 1) + DATA_W'(bus.rx_data[3:0]);
  assign w_acc_sgn  = r_neg ? (~r_acc + DATA_W'(1)) : r_acc;

  always_comb begin
    w_op_ok   = 1'b1;
    w_op_code = '0;
    case (bus.rx_data)
      8'h2B:   w_op_code = OP_W'(6'b100000);
      8'h2D:   w_op_code = OP_W'(6'b100010);
      8'h26:   w_op_code = OP_W'(6'b100100);
      8'h7C:   w_op_code = OP_W'(6'b100101);
      8'h5E:   w_op_code = OP_W'(6'b100110);
      8'h7E:   w_op_code = OP_W'(6'b100111);
      8'h3E:   w_op_code = OP_W'(6'b000011);
      8'h3C:   w_op_code = OP_W'(6'b000010);
      default: w_op_ok   = 1'b0;
    endcase
  end

  // One restoring-division step by 10 per clock; quotient bits shift into r_quot.
  assign w_rem_sh  = {r_rem, r_quot[DATA_W-1]};
  assign w_ge      = (w_rem_sh >= 5'd10);
  assign w_rem_nx  = w_ge ? 4'(w_rem_sh - 5'd10) : w_rem_sh[3:0];
  assign w_quot_nx = {r_quot[DATA_W-2:0], w_ge};

  assign w_res_neg = SIGNED_MODE && bus.alu_result[DATA_W-1];
  assign w_res_mag = w_res_neg ? (~bus.alu_result + DATA_W'(1)) : bus.alu_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_kind     <= K_DIG;
      r_rx_d     <= 1'b1;
      r_tx_d     <= 1'b1;
      r_acc      <= '0;
      r_have     <= 1'b0;
      r_neg      <= 1'b0;
      r_a_pend   <= '0;
      r_op_pend  <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_lat      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_bit      <= '0;
      for (int i = 0; i < MAX_DIGITS; i++) r_dig[i] <= '0;
      r_ndig     <= '0;
      r_tx_idx   <= '0;
      r_res_neg  <= 1'b0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rx_d     <= bus.rx_done;
      r_tx_d     <= bus.tx_done;
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE, S_A_DIG, S_B_DIG: if (w_rx_ev) begin
          if (w_is_dig || w_minus_ok) begin
            if (w_is_dig) begin
              r_acc  <= w_acc_nx;
              r_have <= 1'b1;
            end else begin
              r_neg  <= 1'b1;
            end
            r_state <= (r_state == S_B_DIG) ? S_B_DIG : S_A_DIG;
          end else if (w_is_dlm && r_have) begin
            r_acc  <= '0;
            r_have <= 1'b0;
            r_neg  <= 1'b0;
            if (r_state == S_B_DIG) begin
              r_a     <= r_a_pend;
              r_b     <= w_acc_sgn;
              r_op    <= r_op_pend;
              r_lat   <= LW'(ALU_LAT - 1);
              r_state <= S_ALU_WAIT;
            end else begin
              r_a_pend <= w_acc_sgn;
              r_state  <= S_OPC;
            end
          end else begin
            r_state <= S_ERR;
          end
        end
        S_OPC: if (w_rx_ev) begin
          if (w_op_ok) begin
            r_op_pend <= w_op_code;
            r_state   <= S_OPC_DLM;
          end else begin
            r_state <= S_ERR;
          end
        end
        S_OPC_DLM: if (w_rx_ev) begin
          r_state <= w_is_dlm ? S_B_DIG : S_ERR;
        end
        S_ALU_WAIT: begin
          if (r_lat == '0) begin
            r_quot    <= w_res_mag;
            r_res_neg <= w_res_neg;
            r_rem     <= '0;
            r_bit     <= BW'(DATA_W - 1);
            r_ndig    <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_CONV;
          end else begin
            r_lat <= r_lat - LW'(1);
          end
        end
        S_CONV: begin
          r_rem  <= w_rem_nx;
          r_quot <= w_quot_nx;
          r_bit  <= r_bit - BW'(1);
          if (r_bit == '0) begin
            r_dig[r_ndig] <= w_rem_nx;
            r_ndig        <= r_ndig + IW'(1);
            r_rem         <= '0;
            r_bit         <= BW'(DATA_W - 1);
            if (w_quot_nx == '0) begin
              r_tx_idx <= r_ndig;
              r_kind   <= r_res_neg ? K_SIGN : K_DIG;
              r_state  <= S_TX_BYTE;
            end
          end
        end
        S_TX_BYTE: begin
          r_tx_start <= 1'b1;
          case (r_kind)
            K_SIGN:  r_tx_data <= 8'h2D;
            K_DIG:   r_tx_data <= {4'h3, r_dig[r_tx_idx]};
            K_QMARK: r_tx_data <= 8'h3F;
            K_TERM:  r_tx_data <= TERM;
          endcase
          r_state <= S_TX_WAIT;
        end
        S_TX_WAIT: if (w_tx_ev) begin
          r_state <= S_TX_BYTE;
          case (r_kind)
            K_SIGN:  r_kind <= K_DIG;
            K_DIG: begin
              if (r_tx_idx != '0) r_tx_idx <= r_tx_idx - IW'(1);
              else                r_kind   <= K_TERM;
            end
            K_QMARK: r_kind <= K_TERM;
            K_TERM: begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          endcase
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_acc   <= '0;
          r_have  <= 1'b0;
          r_neg   <= 1'b0;
          r_kind  <= K_QMARK;
          r_state <= S_TX_BYTE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;
  assign bus.A        = r_a;
  assign bus.B        = r_b;
  assign bus.opcode   = r_op;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_uart_alu_frontend.sv
// Directed-frame bench for uart_alu_frontend: expected TX bytes and operand triplets are queued
// by the stimulus and popped by independent monitors on tx_start / rising busy.
module tb_uart_alu_frontend;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_alu_frontend_if #(.DATA_W(DW), .OP_W(6)) bus ();

  uart_alu_frontend #(
    .DATA_W(DW), .OP_W(6), .DELIM(8'h20), .TERM(8'h0D), .MAX_DIGITS(10), .ALU_LAT(1)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_done = 0;
  int n_err_seen = 0;
  int exp_err = 0;
  int tx_delay = 4;
  int tx_hold = 3;

  logic [7:0]       exp_tx [$];
  logic [2*DW+5:0]  exp_abo [$];

  // TX byte scoreboard plus handshake ordering check
  initial begin
    logic [7:0] e_tx;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_start) begin
        checks++;
        if (n_start != n_done) begin
          errors++;
          $display("FAIL tx_handshake: tx_start after %0d starts but %0d done edges", n_start, n_done);
        end
        n_start++;
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got byte %h, expected none", bus.tx_data);
        end else begin
          e_tx = exp_tx.pop_front();
          if (bus.tx_data !== e_tx) begin
            errors++;
            $display("FAIL tx_byte: got %h expected %h", bus.tx_data, e_tx);
          end
        end
      end
    end
  end

  // Operand/opcode scoreboard, sampled when the result is latched
  initial begin
    logic busy_q;
    logic [2*DW+5:0] e_abo;
    busy_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.busy && !busy_q) begin
        checks++;
        if (exp_abo.size() == 0) begin
          errors++;
          $display("FAIL abo_unexpected: busy rose with A=%0d B=%0d op=%b", bus.A, bus.B, bus.opcode);
        end else begin
          e_abo = exp_abo.pop_front();
          if ({bus.A, bus.B, bus.opcode} !== e_abo) begin
            errors++;
            $display("FAIL abo: got A=%h B=%h op=%b expected A=%h B=%h op=%b",
                     bus.A, bus.B, bus.opcode, e_abo[2*DW+5:DW+6], e_abo[DW+5:6], e_abo[5:0]);
          end
        end
      end
      busy_q = bus.busy;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.err) n_err_seen++;
    end
  end

  // UART TX model: tx_done rises tx_delay cycles after tx_start and stays high tx_hold cycles
  initial begin
    int rdly;
    int rhold;
    rdly = -1;
    rhold = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rhold > 0) begin
        rhold--;
        if (rhold == 0) bus.tx_done = 1'b0;
      end
      if (rdly > 0) rdly--;
      else if (rdly == 0) begin
        bus.tx_done = 1'b1;
        n_done++;
        rhold = tx_hold;
        rdly = -1;
      end
      if (!rst && bus.tx_start) rdly = tx_delay;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    bus.rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], hold);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || bus.busy || n_start != n_done || bus.tx_done) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 6000) begin
      errors++;
      $display("FAIL %s_timeout: %0d bytes still pending, busy=%b", name, exp_tx.size(), bus.busy);
    end
    repeat (5) @(negedge clk);
    chk({name, "_busy"}, 64'(bus.busy), 64'd0);
    chk({name, "_errcnt"}, 64'(n_err_seen), 64'(exp_err));
  endtask

  task automatic frame(input string s, input logic [DW-1:0] alu, input string resp,
                       input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic [5:0] eop,
                       input int hold, input string name);
    bus.alu_result = alu;
    exp_abo.push_back({ea, eb, eop});
    for (int i = 0; i < resp.len(); i++) exp_tx.push_back(resp[i]);
    exp_tx.push_back(8'h0D);
    send_str(s, hold);
    wait_idle(name);
  endtask

  task automatic err_frame(input string s, input string name);
    exp_err++;
    exp_tx.push_back(8'h3F);
    exp_tx.push_back(8'h0D);
    send_str(s, 1);
    wait_idle(name);
  endtask

  initial begin
    int t;
    int starts_at_reset;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.alu_result = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
    chk("rst_tx_start", 64'(bus.tx_start), 64'd0);
    chk("rst_A", 64'(bus.A), 64'd0);
    chk("rst_B", 64'(bus.B), 64'd0);
    chk("rst_opcode", 64'(bus.opcode), 64'd0);
    chk("rst_busy_err", 64'({bus.busy, bus.err}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    frame("12 + 30 ", 32'd42, "42", 32'd12, 32'd30, 6'b100000, 1, "add");
    frame("7 & 0 ", 32'd0, "0", 32'd7, 32'd0, 6'b100100, 1, "zero");
`ifdef SIGNED_EN
    frame("4294967296 - 5 ", 32'hFFFFFFFB, "-5", 32'd0, 32'd5, 6'b100010, 1, "wrap");
`else
    frame("4294967296 - 5 ", 32'hFFFFFFFB, "4294967291", 32'd0, 32'd5, 6'b100010, 1, "wrap");
`endif
    err_frame("1x", "bad_digit");
    chk("keep_A", 64'(bus.A), 64'd0);
    chk("keep_B", 64'(bus.B), 64'd5);
    chk("keep_op", 64'(bus.opcode), 64'b100010);
    frame("3 | 4 ", 32'd7, "7", 32'd3, 32'd4, 6'b100101, 1, "or");
    err_frame(" ", "empty_field");
    err_frame("8 q", "bad_op");
    err_frame("8 +1", "no_op_delim");
    frame("255 > 4 ", 32'd15, "15", 32'd255, 32'd4, 6'b000011, 1, "shr");

    tx_delay = 200;
    tx_hold = 20;
    frame("100 ^ 27 ", 32'd127, "127", 32'd100, 32'd27, 6'b100110, 50, "slow");
    tx_delay = 4;
    tx_hold = 3;

`ifdef SIGNED_EN
    frame("-5 + 2 ", 32'hFFFFFFFD, "-3", 32'hFFFFFFFB, 32'd2, 6'b100000, 1, "neg");
    err_frame("- ", "lone_minus");
`else
    err_frame("-", "minus_unsigned");
`endif

    bus.alu_result = 32'd100;
    exp_abo.push_back({32'd99, 32'd1, 6'b100000});
    exp_tx.push_back(8'h31);
    exp_tx.push_back(8'h30);
    exp_tx.push_back(8'h30);
    exp_tx.push_back(8'h0D);
    send_str("99 + 1 ", 1);
    t = 0;
    while (exp_tx.size() > 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL rst_tx_first: first byte never sent, %0d bytes pending", exp_tx.size());
    end
    @(negedge clk);
    rst = 1'b1;
    exp_tx.delete();
    starts_at_reset = n_start;
    #1;
    chk("rstmid_tx_start", 64'(bus.tx_start), 64'd0);
    chk("rstmid_tx_data", 64'(bus.tx_data), 64'd0);
    chk("rstmid_AB", 64'({bus.A, bus.B}), 64'd0);
    chk("rstmid_op_busy", 64'({bus.opcode, bus.busy, bus.err}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("rstmid_no_start", 64'(n_start), 64'(starts_at_reset));
    chk("rstmid_idle_busy", 64'(bus.busy), 64'd0);

    frame("6 < 1 ", 32'd3, "3", 32'd6, 32'd1, 6'b000010, 1, "after_rst");
    chk("abo_drained", 64'(exp_abo.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
